// File: rtl/riscv_alu_arbiter_pkg.sv
//------------------------------------------------------------------------------
// riscv_alu_arbiter_pkg
//   Shared constants for the ALU arbiter: ALU op encodings, the control-word
//   modifier bit position and the requester index values.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_alu_arbiter_pkg;

   // ALU op field, ctr[2:0]; code 3'b111 is a second plain add
   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SLL   = 3'b001;
   localparam logic [2:0] ALU_OP_SLT   = 3'b010;
   localparam logic [2:0] ALU_OP_PASSB = 3'b011;
   localparam logic [2:0] ALU_OP_XOR   = 3'b100;
   localparam logic [2:0] ALU_OP_SR    = 3'b101;
   localparam logic [2:0] ALU_OP_OR    = 3'b110;

   // ctr[3] selects sub / unsigned compare / arithmetic shift
   localparam int ALU_CTR_MOD = 3;

   // Requester indices as stored in the round-robin pointer
   localparam logic ARB_REQ0 = 1'b0;
   localparam logic ARB_REQ1 = 1'b1;

endpackage : riscv_alu_arbiter_pkg

`default_nettype wire

// File: rtl/riscv_alu_arbiter_alu.sv
//------------------------------------------------------------------------------
// riscv_alu_arbiter_alu
//   The shared riscv_alu datapath: add/sub, shifts, set-less-than, pass-B and
//   logic ops. zero/less are only driven for the SLT op and are 0 otherwise.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_alu_arbiter_alu
   import riscv_alu_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTR_W  = 4
) (
   input  logic [CTR_W-1:0]  ctr_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] p_o,
   output logic              zero_o,
   output logic              less_o
);

   localparam int SH_W = $clog2(DATA_W);

   logic [2:0]        op;
   logic              mod;
   logic [SH_W-1:0]   shamt;
   logic              lt_s;
   logic              lt_u;

   assign op    = ctr_i[2:0];
   assign mod   = ctr_i[ALU_CTR_MOD];
   assign shamt = b_i[SH_W-1:0];
   assign lt_s  = $signed(a_i) < $signed(b_i);
   assign lt_u  = a_i < b_i;

   // Result and flag selection by op code
   always_comb begin
      p_o    = a_i + b_i;
      zero_o = 1'b0;
      less_o = 1'b0;
      case (op)
         ALU_OP_ADD: begin
            if (mod) p_o = a_i - b_i;
            else     p_o = a_i + b_i;
         end
         ALU_OP_SLL:   p_o = a_i << shamt;
         ALU_OP_SLT: begin
            less_o = mod ? lt_u : lt_s;
            zero_o = (a_i == b_i);
            p_o    = {{(DATA_W-1){1'b0}}, less_o};
         end
         ALU_OP_PASSB: p_o = b_i;
         ALU_OP_XOR:   p_o = a_i ^ b_i;
         ALU_OP_SR: begin
            // kept as separate assignments so the signed shift is not
            // flattened to unsigned by a shared expression context
            if (mod) p_o = $unsigned($signed(a_i) >>> shamt);
            else     p_o = a_i >> shamt;
         end
         ALU_OP_OR:    p_o = a_i | b_i;
         default:      p_o = a_i + b_i;
      endcase
   end

endmodule : riscv_alu_arbiter_alu

`default_nettype wire

// File: rtl/riscv_alu_arbiter.sv
//------------------------------------------------------------------------------
// riscv_alu_arbiter
//   Shares one ALU between the EX-stage pipe (req0) and the address/branch
//   path (req1). One grant per cycle, result captured into a one-entry
//   response register per requester, visible the cycle after accept.
//   Build option: RISCV_ALU_ARB_FIXED_PRIO_EN selects fixed priority
//   (req0 always wins); otherwise round-robin with req0 winning the first tie.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_alu_arbiter
   import riscv_alu_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTR_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [CTR_W-1:0]  req0_ctr_i,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [CTR_W-1:0]  req1_ctr_i,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   output logic [DATA_W-1:0] rsp0_p_o,
   output logic              rsp0_zero_o,
   output logic              rsp0_less_o,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [DATA_W-1:0] rsp1_p_o,
   output logic              rsp1_zero_o,
   output logic              rsp1_less_o
);

   logic [1:0]        req_valid;
   logic [1:0]        rsp_ready;
   logic [1:0]        rsp_valid;
   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [CTR_W-1:0]  alu_ctr;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_p;
   logic              alu_zero;
   logic              alu_less;

   assign req_valid = {req1_valid_i, req0_valid_i};
   assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

`ifndef RISCV_ALU_ARB_FIXED_PRIO_EN
   logic last_grant_q;
   logic last_grant_d;
`endif

   // Eligibility (drain and refill in one cycle allowed) and grant selection
   always_comb begin
      elig  = req_valid & (~rsp_valid | rsp_ready);
      grant = 2'b00;
`ifdef RISCV_ALU_ARB_FIXED_PRIO_EN
      if (elig[0])      grant[0] = 1'b1;
      else if (elig[1]) grant[1] = 1'b1;
`else
      if (elig == 2'b11) begin
         if (last_grant_q == ARB_REQ0) grant[1] = 1'b1;
         else                          grant[0] = 1'b1;
      end else begin
         grant = elig;
      end
`endif
   end

   assign req0_ready_o = grant[0];
   assign req1_ready_o = grant[1];

`ifndef RISCV_ALU_ARB_FIXED_PRIO_EN
   // Round-robin pointer follows every grant, holds when idle
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant[1])      last_grant_d = ARB_REQ1;
      else if (grant[0]) last_grant_d = ARB_REQ0;
   end

   // Pointer resets to req1 so that req0 wins the first tie
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) last_grant_q <= ARB_REQ1;
      else          last_grant_q <= last_grant_d;
   end
`endif

   // ALU operand mux; idle cycles present req0 operands and are discarded
   always_comb begin
      alu_ctr = req0_ctr_i;
      alu_a   = req0_a_i;
      alu_b   = req0_b_i;
      if (grant[1]) begin
         alu_ctr = req1_ctr_i;
         alu_a   = req1_a_i;
         alu_b   = req1_b_i;
      end
   end

   riscv_alu_arbiter_alu #(
      .DATA_W (DATA_W),
      .CTR_W  (CTR_W)
   ) u_riscv_alu (
      .ctr_i  (alu_ctr),
      .a_i    (alu_a),
      .b_i    (alu_b),
      .p_o    (alu_p),
      .zero_o (alu_zero),
      .less_o (alu_less)
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic              valid_q;
      logic              valid_d;
      logic [DATA_W-1:0] p_q;
      logic [DATA_W-1:0] p_d;
      logic              zero_q;
      logic              zero_d;
      logic              less_q;
      logic              less_d;

      // Load on grant, otherwise clear valid on consume; data holds
      always_comb begin
         valid_d = valid_q;
         p_d     = p_q;
         zero_d  = zero_q;
         less_d  = less_q;
         if (grant[gi]) begin
            valid_d = 1'b1;
            p_d     = alu_p;
            zero_d  = alu_zero;
            less_d  = alu_less;
         end else if (rsp_ready[gi] && valid_q) begin
            valid_d = 1'b0;
         end
      end

      // Response register, cleared asynchronously
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            valid_q <= 1'b0;
            p_q     <= '0;
            zero_q  <= 1'b0;
            less_q  <= 1'b0;
         end else begin
            valid_q <= valid_d;
            p_q     <= p_d;
            zero_q  <= zero_d;
            less_q  <= less_d;
         end
      end
   end

   assign rsp_valid    = {g_rsp[1].valid_q, g_rsp[0].valid_q};
   assign rsp0_valid_o = g_rsp[0].valid_q;
   assign rsp0_p_o     = g_rsp[0].p_q;
   assign rsp0_zero_o  = g_rsp[0].zero_q;
   assign rsp0_less_o  = g_rsp[0].less_q;
   assign rsp1_valid_o = g_rsp[1].valid_q;
   assign rsp1_p_o     = g_rsp[1].p_q;
   assign rsp1_zero_o  = g_rsp[1].zero_q;
   assign rsp1_less_o  = g_rsp[1].less_q;

endmodule : riscv_alu_arbiter

`default_nettype wire
